// File: rtl/seqgen_pkg.sv
// Shared definitions for the serial pattern transmitter and its detector partner.
package seqgen_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } seqgen_state_e;

  // Default frame, also the pattern the detector is built to recognise.
  localparam logic [3:0] SEQ_DEF_PATTERN = 4'b1011;

endpackage

// File: rtl/seq_piso.sv
// Parallel-load, serial-out shift register; MSB is presented first.
module seq_piso #(
  parameter int W = 4
) (
  input  logic         clock_i,
  input  logic         reset_ni,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] data_i,
  output logic         msb_o
);

  logic [W-1:0] sr_q;

  // Load has priority over shift; shifting fills with zero from the bottom.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= data_i;
    end else if (shift_i) begin
      sr_q <= {sr_q[W-2:0], 1'b0};
    end
  end

  assign msb_o = sr_q[W-1];

endmodule

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: sends a latched frame MSB-first, repeated a
// programmable number of times with a programmable idle gap between frames.
//
//   state  | meaning
//   S_IDLE | waiting for start; done pulses here for one cycle after a burst
//   S_SEND | a frame bit is on sequence_o (valid_o=1)
//   S_GAP  | idle cycles between frames (valid_o=0, busy_o=1)
module sequence_generator
  import seqgen_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP_W = 3,
  parameter logic [PAT_W-1:0] DEF_PATTERN = PAT_W'(SEQ_DEF_PATTERN)
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             start_i,
  input  logic             use_default_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic [CNT_W-1:0] repeat_count_i,
  input  logic [GAP_W-1:0] gap_len_i,
  input  logic             abort_i,
  output logic             sequence_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int BW = $clog2(PAT_W);
  localparam logic [BW-1:0]    BIT_LAST   = BW'(PAT_W - 1);
  localparam logic [CNT_W-1:0] FRAMES_ONE = CNT_W'(1);
  localparam logic [GAP_W-1:0] GAP_ONE    = GAP_W'(1);

  seqgen_state_e    state_q;
  logic [PAT_W-1:0] pat_q;
  logic [CNT_W-1:0] frames_q;
  logic [GAP_W-1:0] gap_len_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic [BW-1:0]    bit_q;
  logic             seq_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;

  logic [PAT_W-1:0] pat_sel_d;
  logic [CNT_W-1:0] frames_init_d;
  logic             accept;
  logic             last_bit;
  logic             reload;
  logic             first_bit;
  logic             piso_load;
  logic             piso_shift;
  logic [PAT_W-1:0] piso_data;
  logic             piso_msb;

  // Decode which edge starts a frame or advances the shift register.
  // The shift register is loaded pre-shifted by one: the MSB goes straight
  // to the output register on the frame-start edge, so the register then
  // only has to supply the remaining bits.
  always_comb begin
    pat_sel_d     = use_default_i ? DEF_PATTERN : pattern_i;
    frames_init_d = (repeat_count_i == '0) ? FRAMES_ONE : repeat_count_i;
    accept        = (state_q == S_IDLE) && start_i && !abort_i;
    last_bit      = (bit_q == BIT_LAST);
    reload        = ((state_q == S_SEND) && !abort_i && last_bit &&
                     (frames_q != FRAMES_ONE) && (gap_len_q == '0)) ||
                    ((state_q == S_GAP) && !abort_i && (gap_cnt_q == GAP_ONE));
    first_bit     = accept ? pat_sel_d[PAT_W-1] : pat_q[PAT_W-1];
    piso_load     = accept || reload;
    piso_data     = accept ? {pat_sel_d[PAT_W-2:0], 1'b0} : {pat_q[PAT_W-2:0], 1'b0};
    piso_shift    = (state_q == S_SEND) && !abort_i && !last_bit;
  end

  seq_piso #(
    .W(PAT_W)
  ) u_piso (
    .clock_i  (clock_i),
    .reset_ni (reset_ni),
    .load_i   (piso_load),
    .shift_i  (piso_shift),
    .data_i   (piso_data),
    .msb_o    (piso_msb)
  );

  // Main sequencer: state, frame/gap counters and all registered outputs.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= S_IDLE;
      pat_q     <= '0;
      frames_q  <= '0;
      gap_len_q <= '0;
      gap_cnt_q <= '0;
      bit_q     <= '0;
      seq_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            pat_q     <= pat_sel_d;
            frames_q  <= frames_init_d;
            gap_len_q <= gap_len_i;
            gap_cnt_q <= '0;
            bit_q     <= '0;
            seq_q     <= first_bit;
            valid_q   <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= S_SEND;
          end
        end
        S_SEND: begin
          if (abort_i) begin
            state_q  <= S_IDLE;
            frames_q <= '0;
            bit_q    <= '0;
            seq_q    <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
          end else if (!last_bit) begin
            bit_q <= bit_q + BW'(1);
            seq_q <= piso_msb;
          end else if (frames_q == FRAMES_ONE) begin
            state_q  <= S_IDLE;
            frames_q <= '0;
            bit_q    <= '0;
            seq_q    <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            frames_q <= frames_q - FRAMES_ONE;
            bit_q    <= '0;
            if (reload) begin
              // Zero gap: next frame follows with no bubble.
              seq_q <= first_bit;
            end else begin
              gap_cnt_q <= gap_len_q;
              seq_q     <= 1'b0;
              valid_q   <= 1'b0;
              state_q   <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (abort_i) begin
            state_q   <= S_IDLE;
            frames_q  <= '0;
            gap_cnt_q <= '0;
            busy_q    <= 1'b0;
          end else if (gap_cnt_q == GAP_ONE) begin
            gap_cnt_q <= '0;
            seq_q     <= first_bit;
            valid_q   <= 1'b1;
            state_q   <= S_SEND;
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_ONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          seq_q   <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sequence_o = seq_q;
  assign valid_o    = valid_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: doc/sequence_generator.md
Name: sequence_generator

Overview:
- Serial pattern transmitter: the driving end of the serial bit stream consumed by the `sequencedetector` block.
- Latches a PAT_W-bit pattern and shifts it out MSB-first, one bit per clock.
- Supports a programmable repeat count and programmable idle gap between frames, with a start/busy/done handshake.
- Used as on-chip stimulus source and loopback partner for the detector.

Parameters:
- PAT_W, 4, pattern length in bits (>=2).
- CNT_W, 4, width of repeat_count.
- GAP_W, 3, width of gap_len.
- DEF_PATTERN, 4'b1011, pattern used when use_default=1.

Ports:
- clock  input  1  single system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request to begin a burst; sampled only in IDLE.
- use_default  input  1  1: send DEF_PATTERN, 0: send pattern input; sampled with start.
- pattern  input  PAT_W  frame bits, MSB transmitted first; sampled with start.
- repeat_count  input  CNT_W  frames per burst; 0 is treated as 1; sampled with start.
- gap_len  input  GAP_W  idle cycles between consecutive frames; sampled with start.
- abort  input  1  synchronous cancel of the current burst.
- sequence  output  1  serial data bit; 0 whenever valid=0.
- valid  output  1  sequence carries a frame bit this cycle.
- busy  output  1  high from the accepting edge until return to IDLE.
- done  output  1  one-cycle pulse after the last bit of a completed burst.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; sequence=0, valid=0, busy=0, done=0; all internal counters and shift register cleared. Applies immediately, including mid-frame; no done is produced.
- All outputs are registered.
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - done is low except for its single pulse cycle.
  - On an edge with start=1 and abort=0: latch the pattern (or DEF_PATTERN), frames_left = max(repeat_count,1), gap_len; go to SEND.
  - The same edge drives sequence=pattern[PAT_W-1], valid=1, busy=1. Latency from the start edge to the first bit is 0 cycles, registered.
- SEND:
  - One bit per edge, MSB first. bit_cnt counts 0..PAT_W-1.
  - After bit PAT_W-1, decrement frames_left:
    - If frames_left becomes 0: go to IDLE; next cycle valid=0, busy=0, done=1 for exactly one cycle.
    - Else if gap_len=0: reload the shift register and send the next frame back-to-back with no bubble.
    - Else go to GAP.
- GAP:
  - valid=0, sequence=0, busy=1 for exactly gap_len cycles.
  - Then return to SEND with the reloaded pattern.
- abort=1 in SEND or GAP:
  - Next edge goes to IDLE with valid=0, busy=0; done is NOT pulsed.
  - abort in IDLE has no effect, and blocks a simultaneous start.
- start while busy=1 is ignored; it does not queue.
- start coincident with the done-pulse cycle (state already IDLE) is accepted. done=1 and valid=1 may then overlap for one cycle.
- Counter widths: frames_left is CNT_W bits and gap_cnt is GAP_W bits. Neither wraps: the FSM exits before underflow.
- Burst length in cycles = R*PAT_W + (R-1)*G, where R=max(repeat_count,1) and G=gap_len.

Decomposition:
- Package `seqgen_pkg`:
  - State encoding localparams S_IDLE=2'd0, S_SEND=2'd1, S_GAP=2'd2.
  - DEF_PATTERN value, shared with the detector bench.
- One sub-module: `seq_piso`, a PAT_W-bit parallel-load, serial-out shift register.
  - Inputs: load, shift, parallel data. Output: MSB.
  - Same clock and active-low asynchronous reset.
- FSM and counters stay in the top module.

Test Plan:
- Single frame: start=1, use_default=1, repeat=1, gap=0.
  - sequence = 1,0,1,1 on 4 consecutive cycles; valid high for 4 cycles; busy high for 4 cycles.
  - done=1 on cycle 5 only.
- Repeat with gap: pattern=4'b0110, repeat=2, gap=2.
  - sequence/valid = 0/1,1/1,1/1,0/1, 0/0,0/0, 0/1,1/1,1/1,0/1.
  - Total 10 busy cycles, then a single done pulse.
- Back-to-back and zero repeat: repeat=0, gap=0 sends exactly one frame. repeat=3, gap=0 sends 12 contiguous valid cycles with no bubble.
- Abort and ignored start:
  - abort asserted during bit 2 of frame 1 (repeat=2): valid and busy drop next cycle, done never asserts.
  - start pulsed while busy: no effect on the stream.
- Asynchronous reset mid-GAP: reset=0 between clock edges forces all outputs to 0 immediately. After release, a fresh start behaves as in the single-frame scenario.
- Loopback: drive `sequencedetector.sequence` from this block with DEF_PATTERN, repeat=3, gap=1.
  - detector asserts exactly 3 times, each one cycle after that frame's final bit.
